freq_shift_stream: RTL
======================

# freq_shift_stream

Parametrised spectral bin shifter placed between the FFT output stream and the IFFT/resynthesis stage of the voice path. It buffers one FFT frame of FRAME_LEN bins in a ping-pong bank pair. It then replays the frame with every bin moved up (raise pitch) or down (lower pitch) by a runtime bin count, zero-filling vacated bins. It generalises the fixed 32-bin raise stage: it supports configurable width, frame length, direction and shift amount, output backpressure, malformed-frame detection, and sustained one-bin-per-cycle streaming on a single clock.

## Interface
- DATA_W, 32, bin word width; packed {re[DATA_W/2], im[DATA_W/2]}, passed through unmodified
- FRAME_LEN, 32, bins per frame; power of two, 4..256
- BIN_W, $clog2(FRAME_LEN), bin index width (derived, do not override)

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input bin valid
- in_ready  out  1  block accepts a bin this cycle
- in_data  in  DATA_W  input bin word, bins arrive in order 0..FRAME_LEN-1
- in_fin  in  1  marks the last bin of a frame
- shift_amt  in  BIN_W  shift in bins, sampled at frame read start
- shift_dir  in  1  1 = raise (toward higher bins), 0 = lower
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_W  shifted bin word
- out_bin  out  BIN_W  output bin index
- out_fin  out  1  asserted with out_bin = FRAME_LEN-1
- frame_err  out  1  one-cycle pulse on a malformed input frame

## Operation
- Two banks, each FRAME_LEN x DATA_W, with a FRAME_LEN-bit written mask, a full flag, a write pointer wr_bank and a read pointer rd_bank.
- Write: in_ready = !full[wr_bank]. On accept, data goes to mem[wr_bank][wr_cnt], the mask bit is set, and wr_cnt increments.
- Bank close occurs when wr_cnt = FRAME_LEN-1 is accepted, or on an accepted in_fin. On close: full[wr_bank] is set, wr_bank toggles, wr_cnt clears, and the new bank's mask clears.
- frame_err pulses when in_fin and wr_cnt = FRAME_LEN-1 disagree on the closing beat. Bins of a short frame that were never written read as zero.
- Reader FSM states:
  - IDLE -> READ when full[rd_bank] is set. Latch shift_amt/shift_dir at this transition and set rd_cnt = 0.
  - READ presents bin rd_cnt and advances on an out_valid && out_ready handshake.
  - After the out_fin handshake: clear full[rd_bank], toggle rd_bank, go to IDLE (or straight to READ if the other bank is full).
- Source index for output bin k:
  - raise: src = k - s if k >= s, else none
  - lower: src = k + s if k + s < FRAME_LEN, else none
  - "none" or an unwritten mask bit gives out_data = 0
  - s = 0 is pass-through
- Output register: out_data, out_bin and out_fin are registered. They hold stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_bin 0, out_fin 0, frame_err 0. Both banks are empty; wr_bank = rd_bank = 0; the FSM is in IDLE.
- Latency: if the closing beat is accepted at edge T, the reader enters READ at T+1 and first out_valid is high after T+2.
- Throughput: 1 bin/cycle with out_ready held high. Back-to-back frames stream with no input stall.
- in_ready drops only when both banks are full. It rises the cycle after the reader releases a bank.
- Close and release on opposite banks in the same cycle are both honoured.
- shift_amt/shift_dir changes mid-frame have no effect until the next READ entry.
- rst_n asserted mid-frame discards all buffered data and forces the reset values immediately (asynchronous assert). Deassertion is synchronous to clk.

## Configuration
- FREQ_SHIFT_LOWER_EN defined: shift_dir is honoured as above.
- FREQ_SHIFT_LOWER_EN undefined: lower-direction logic is removed, shift_dir is ignored, and the block always raises.

## Test plan
- Reset, then a ramp frame in_data = bin index, shift_amt = 0 -> out_data = 0..31 in order, out_fin on bin 31, first out_valid 2 cycles after the last accept.
- Raise, shift_amt = 3 -> out bins 0..2 = 0, out bin k = k-3 for k >= 3; out_fin on bin 31.
- Lower, shift_amt = 5 (macro defined) -> out bin k = k+5 for k <= 26, bins 27..31 = 0. With the macro undefined, the same stimulus produces the raise-by-5 result.
- Three back-to-back frames with out_ready toggling 1-0-1 -> no bins lost or duplicated, out_data stable while stalled, in_ready low only while both banks are full.
- in_fin asserted on bin 19 -> frame_err single pulse; bins 20..31 of that frame output as zero; the next frame is unaffected.
- rst_n pulsed low mid-READ -> out_valid falls immediately, and the next full frame is output correctly from bin 0.

Source files
------------

// File: rtl/freq_shift_stream.sv
// Ping-pong frame buffer that replays each FFT frame with every bin shifted up or down by shift_amt.
// Define FREQ_SHIFT_LOWER_EN to honour shift_dir; otherwise the block always raises.
module freq_shift_stream #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 32,
    parameter int BIN_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_fin,
    input  logic [BIN_W-1:0]  shift_amt,
    input  logic              shift_dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [BIN_W-1:0]  out_bin,
    output logic              out_fin,
    output logic              frame_err
);

    localparam logic [0:0]       IDLE = 1'b0;
    localparam logic [0:0]       READ = 1'b1;
    localparam logic [BIN_W-1:0] LAST = BIN_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0]          mem [2*FRAME_LEN];
    logic [1:0][FRAME_LEN-1:0]  mask;
    logic [1:0]                 full;
    logic                       wr_bank;
    logic                       rd_bank;
    logic [BIN_W-1:0]           wr_cnt;
    logic [BIN_W-1:0]           rd_cnt;
    logic [BIN_W-1:0]           amt_reg;
    logic                       issue_done;
    logic [0:0]                 state;

    logic                       accept;
    logic                       close;
    logic                       fin_hs;
    logic                       chain;
    logic                       load_cont;
    logic                       load;
    logic                       sel_bank;
    logic [BIN_W-1:0]           sel_cnt;
    logic [BIN_W-1:0]           sel_amt;
    logic [BIN_W:0]             raise_idx;
    logic [BIN_W:0]             src_idx;
    logic                       hit;
    logic [BIN_W:0]             rd_addr;

`ifdef FREQ_SHIFT_LOWER_EN
    logic                       dir_reg;
    logic                       sel_dir;
    logic [BIN_W:0]             lower_idx;
`else
    logic                       unused_dir;
    assign unused_dir = shift_dir;
`endif

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign close     = accept && (in_fin || (wr_cnt == LAST));
    assign fin_hs    = (state == READ) && out_valid && out_ready && out_fin;
    // Chaining loads bin 0 of the next full bank on the same edge the last bin leaves.
    assign chain     = fin_hs && full[!rd_bank];
    assign load_cont = (state == READ) && !issue_done && (!out_valid || out_ready);
    assign load      = load_cont || chain;

    always_comb begin
        sel_bank = rd_bank;
        sel_cnt  = rd_cnt;
        sel_amt  = amt_reg;
        if (chain) begin
            sel_bank = !rd_bank;
            sel_cnt  = '0;
            sel_amt  = shift_amt;
        end
    end

    // The top bit flags a borrow (raise) or carry (lower): the source bin falls off the frame.
    assign raise_idx = {1'b0, sel_cnt} - {1'b0, sel_amt};
`ifdef FREQ_SHIFT_LOWER_EN
    assign sel_dir   = chain ? shift_dir : dir_reg;
    assign lower_idx = {1'b0, sel_cnt} + {1'b0, sel_amt};
    assign src_idx   = sel_dir ? raise_idx : lower_idx;
`else
    assign src_idx   = raise_idx;
`endif
    assign hit     = !src_idx[BIN_W] && mask[sel_bank][src_idx[BIN_W-1:0]];
    assign rd_addr = {sel_bank, src_idx[BIN_W-1:0]};

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank, wr_cnt}] <= in_data;
        end
    end

    // Masks clear on release rather than on close so a bank still being replayed is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            mask      <= '0;
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= close && (in_fin != (wr_cnt == LAST));
            if (accept) begin
                mask[wr_bank][wr_cnt] <= 1'b1;
            end
            if (close) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= !wr_bank;
                wr_cnt        <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + BIN_W'(1);
            end
            if (fin_hs) begin
                full[rd_bank] <= 1'b0;
                mask[rd_bank] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            issue_done <= 1'b0;
            amt_reg    <= '0;
`ifdef FREQ_SHIFT_LOWER_EN
            dir_reg    <= 1'b1;
`endif
        end else if (state == IDLE) begin
            if (full[rd_bank]) begin
                state      <= READ;
                rd_cnt     <= '0;
                issue_done <= 1'b0;
                amt_reg    <= shift_amt;
`ifdef FREQ_SHIFT_LOWER_EN
                dir_reg    <= shift_dir;
`endif
            end
        end else begin
            if (load_cont) begin
                rd_cnt <= rd_cnt + BIN_W'(1);
                if (rd_cnt == LAST) begin
                    issue_done <= 1'b1;
                end
            end
            if (fin_hs) begin
                rd_bank <= !rd_bank;
                if (chain) begin
                    rd_cnt     <= BIN_W'(1);
                    issue_done <= 1'b0;
                    amt_reg    <= shift_amt;
`ifdef FREQ_SHIFT_LOWER_EN
                    dir_reg    <= shift_dir;
`endif
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bin   <= '0;
            out_fin   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= hit ? mem[rd_addr] : '0;
            out_bin   <= sel_cnt;
            out_fin   <= (sel_cnt == LAST);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
